// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor and the exe-stage update path.
package branch_predictor_pkg;

    localparam int unsigned BP_INDEX_BITS = 6;
    localparam int unsigned BP_TAG_BITS   = 10;
    localparam int unsigned BP_XLEN       = 64;

    // 2-bit saturating direction counter
    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_SNT = 2'b00;
    localparam bht_cnt_t BHT_WNT = 2'b01;
    localparam bht_cnt_t BHT_WT  = 2'b10;
    localparam bht_cnt_t BHT_ST  = 2'b11;

    // One branch target buffer entry
    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_BITS-1:0]   tag;
        logic                     is_jump;
        logic [BP_XLEN-1:0]       target;
    } btb_entry_t;

    // Resolution bundle coming back from the exe-stage branch unit
    typedef struct packed {
        logic                 valid;
        logic [BP_XLEN-1:0]   pc;
        logic                 is_jump;
        logic                 taken;
        logic [BP_XLEN-1:0]   target;
    } bpred_upd_t;

    // Predictor control states: table sweep after reset, then normal service
    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Saturating counter step: count up on taken, down on not-taken, hold at the ends
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t result;
        result = cnt;
        if (taken) begin
            if (cnt != BHT_ST) begin
                result = cnt + 2'd1;
            end
        end else begin
            if (cnt != BHT_SNT) begin
                result = cnt - 2'd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped predictor storage: one forwarded lookup read port, one raw
// read-modify-write read port, and one write port. Used for both BHT and BTB.
module bpred_table #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned WIDTH      = 2
) (
    input  logic                  clk_i,
    input  logic [INDEX_BITS-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o,
    input  logic [INDEX_BITS-1:0] rmw_addr_i,
    output logic [WIDTH-1:0]      rmw_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] mem_d [ENTRIES];

    // Next array contents: copy everything, overwrite the addressed entry on a write
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage has no reset; the owner sweeps it into a known state
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Lookup port sees this cycle's write to the same entry (write-first)
    always_comb begin
        rd_data_o = mem_q[rd_addr_i];
        if (we_i && (waddr_i == rd_addr_i)) begin
            rd_data_o = wdata_i;
        end
    end

    // Update port reads the pre-write value so the owner can compute the new one
    always_comb begin
        rmw_data_o = mem_q[rmw_addr_i];
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter BHT plus tagged BTB, one lookup
// per cycle with one cycle of latency and one exe resolution per cycle.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = BP_INDEX_BITS,
    parameter int unsigned TAG_BITS   = BP_TAG_BITS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        ready_o,
    input  logic        lookup_valid_i,
    input  logic [63:0] lookup_pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [63:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [63:0] upd_pc_i,
    input  logic        upd_is_jump_i,
    input  logic        upd_taken_i,
    input  logic [63:0] upd_target_i
);

    localparam int unsigned BTB_WIDTH = $bits(btb_entry_t);
    localparam int unsigned TAG_LSB   = INDEX_BITS + 2;
    localparam int unsigned TAG_MSB   = INDEX_BITS + TAG_BITS + 1;

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [63:0]           pred_target_q, pred_target_d;

    bpred_upd_t            upd;
    logic [INDEX_BITS-1:0] lookup_idx, upd_idx;
    logic [TAG_BITS-1:0]   lookup_tag, upd_tag;

    logic                  bht_we;
    logic [INDEX_BITS-1:0] bht_waddr;
    bht_cnt_t              bht_wdata;
    bht_cnt_t              bht_rd;
    bht_cnt_t              bht_rmw;

    logic                  btb_we;
    logic [INDEX_BITS-1:0] btb_waddr;
    btb_entry_t            btb_wdata;
    btb_entry_t            btb_rd;
    logic [BTB_WIDTH-1:0]  btb_rd_raw;
    logic [BTB_WIDTH-1:0]  btb_rmw_unused;

    logic                  lookup_fire;
    logic                  lookup_hit;
    logic                  lookup_taken;
    logic                  unused_pc_bits;

    // Bundle the resolution ports the way exe produces them and split PCs into index/tag
    always_comb begin
        upd.valid   = upd_valid_i;
        upd.pc      = upd_pc_i;
        upd.is_jump = upd_is_jump_i;
        upd.taken   = upd_taken_i;
        upd.target  = upd_target_i;
        lookup_idx  = lookup_pc_i[INDEX_BITS+1:2];
        lookup_tag  = lookup_pc_i[TAG_MSB:TAG_LSB];
        upd_idx     = upd.pc[INDEX_BITS+1:2];
        upd_tag     = upd.pc[TAG_MSB:TAG_LSB];
    end

    assign unused_pc_bits = ^{lookup_pc_i[63:TAG_MSB+1], lookup_pc_i[1:0],
                              upd_pc_i[63:TAG_MSB+1], upd_pc_i[1:0]};

    // State register and sweep counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BP_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every entry once, then serve forever until the next reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BP_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                state_d = BP_RUN;
            end
            default: begin
                state_d = BP_INIT;
            end
        endcase
    end

    // Table write control: sweep writes during INIT, exe resolutions during RUN
    always_comb begin
        bht_we    = 1'b0;
        bht_waddr = upd_idx;
        bht_wdata = bht_next(bht_rmw, upd.taken);
        btb_we    = 1'b0;
        btb_waddr = upd_idx;
        btb_wdata = '{valid: 1'b1, tag: upd_tag, is_jump: upd.is_jump, target: upd.target};
        if (!rst_i) begin
            case (state_q)
                BP_INIT: begin
                    bht_we    = 1'b1;
                    bht_waddr = cnt_q;
                    bht_wdata = BHT_WNT;
                    btb_we    = 1'b1;
                    btb_waddr = cnt_q;
                    btb_wdata = '0;
                end
                BP_RUN: begin
                    bht_we = upd.valid && !upd.is_jump;
                    btb_we = upd.valid && upd.taken;
                end
                default: begin
                    bht_we = 1'b0;
                    btb_we = 1'b0;
                end
            endcase
        end
    end

    bpred_table #(
        .INDEX_BITS (INDEX_BITS),
        .WIDTH      ($bits(bht_cnt_t))
    ) u_bht (
        .clk_i      (clk_i),
        .rd_addr_i  (lookup_idx),
        .rd_data_o  (bht_rd),
        .rmw_addr_i (upd_idx),
        .rmw_data_o (bht_rmw),
        .we_i       (bht_we),
        .waddr_i    (bht_waddr),
        .wdata_i    (bht_wdata)
    );

    bpred_table #(
        .INDEX_BITS (INDEX_BITS),
        .WIDTH      (BTB_WIDTH)
    ) u_btb (
        .clk_i      (clk_i),
        .rd_addr_i  (lookup_idx),
        .rd_data_o  (btb_rd_raw),
        .rmw_addr_i (upd_idx),
        .rmw_data_o (btb_rmw_unused),
        .we_i       (btb_we),
        .waddr_i    (btb_waddr),
        .wdata_i    (btb_wdata)
    );

    // Prediction from the forwarded table reads; jumps ignore the direction counter
    always_comb begin
        btb_rd        = btb_entry_t'(btb_rd_raw);
        lookup_fire   = (state_q == BP_RUN) && lookup_valid_i;
        lookup_hit    = btb_rd.valid && (btb_rd.tag == lookup_tag);
        lookup_taken  = lookup_hit && (btb_rd.is_jump || bht_rd[1]);
        pred_valid_d  = lookup_fire;
        pred_taken_d  = lookup_fire && lookup_taken;
        pred_target_d = pred_taken_d ? btb_rd.target : 64'd0;
        ready_d       = (state_d == BP_RUN);
    end

    // Registered outputs, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q       <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 64'd0;
        end else begin
            ready_q       <= ready_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign ready_o       = ready_q;
    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic
// checked against a table-level behavioural model.
module tb_branch_predictor;

   typedef struct {
      bit          taken;
      logic [63:0] target;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        readyOut;
   logic        lookupValid;
   logic [63:0] lookupPc;
   logic        predValid;
   logic        predTaken;
   logic [63:0] predTarget;
   logic        updValid;
   logic [63:0] updPc;
   logic        updIsJump;
   logic        updTaken;
   logic [63:0] updTarget;

   int          assertCount = 0;
   int          failCount   = 0;
   exp_t        expQ[$];

   int          modelInitLeft;
   int          modelCnt[64];
   bit          modelValid[64];
   int          modelTag[64];
   bit          modelJump[64];
   logic [63:0] modelTarget[64];

   branch_predictor dut (
      .clk_i          (clock),
      .rst_i          (reset),
      .ready_o        (readyOut),
      .lookup_valid_i (lookupValid),
      .lookup_pc_i    (lookupPc),
      .pred_valid_o   (predValid),
      .pred_taken_o   (predTaken),
      .pred_target_o  (predTarget),
      .upd_valid_i    (updValid),
      .upd_pc_i       (updPc),
      .upd_is_jump_i  (updIsJump),
      .upd_taken_i    (updTaken),
      .upd_target_i   (updTarget)
   );

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int pcIndex(input logic [63:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic int pcTag(input logic [63:0] pc);
      return int'((pc >> 8) % 1024);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Model reset: after the sweep every counter is weak-not-taken and every BTB slot empty
   task automatic modelReset();
      modelInitLeft = 64;
      for (int i = 0; i < 64; i++) begin
         modelCnt[i]    = 1;
         modelValid[i]  = 1'b0;
         modelTag[i]    = 0;
         modelJump[i]   = 1'b0;
         modelTarget[i] = 64'd0;
      end
   endtask

   // Drive one cycle of inputs, advance the model for that edge, then step past the edge
   task automatic applyStimulus(input bit lv, input logic [63:0] lpc,
                                input bit uv, input logic [63:0] upc,
                                input bit isJump, input bit taken, input logic [63:0] tgt);
      int ui;
      int li;
      bit hit;
      bit predT;
      exp_t e;
      lookupValid = lv;
      lookupPc    = lpc;
      updValid    = uv;
      updPc       = upc;
      updIsJump   = isJump;
      updTaken    = taken;
      updTarget   = tgt;
      if (modelInitLeft > 0) begin
         modelInitLeft--;
      end else begin
         if (uv) begin
            ui = pcIndex(upc);
            if (!isJump) begin
               if (taken) modelCnt[ui] = (modelCnt[ui] >= 3) ? 3 : modelCnt[ui] + 1;
               else       modelCnt[ui] = (modelCnt[ui] <= 0) ? 0 : modelCnt[ui] - 1;
            end
            if (taken) begin
               modelValid[ui]  = 1'b1;
               modelTag[ui]    = pcTag(upc);
               modelJump[ui]   = isJump;
               modelTarget[ui] = tgt;
            end
         end
         if (lv) begin
            li       = pcIndex(lpc);
            hit      = modelValid[li] && (modelTag[li] == pcTag(lpc));
            predT    = hit && (modelJump[li] || (modelCnt[li] >= 2));
            e.taken  = predT;
            e.target = predT ? modelTarget[li] : 64'd0;
            expQ.push_back(e);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic lookupOnly(input logic [63:0] pc);
      applyStimulus(1'b1, pc, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic updateOnly(input logic [63:0] pc, input bit isJump, input bit taken, input logic [63:0] tgt);
      applyStimulus(1'b0, 64'd0, 1'b1, pc, isJump, taken, tgt);
   endtask

   task automatic pulseReset(input int cycles);
      reset       = 1'b1;
      lookupValid = 1'b0;
      updValid    = 1'b0;
      repeat (cycles) begin
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
      modelReset();
   endtask

   // Init sweep: ready must stay low for 63 edges and rise on the 64th
   task automatic checkInitSweep(input bit probeLookup);
      for (int i = 1; i <= 64; i++) begin
         if (probeLookup && (i == 5)) lookupOnly(64'h1000);
         else                         idleCycle();
         checkOutput($sformatf("ready_cycle%0d", i), {63'd0, readyOut}, (i == 64) ? 64'd1 : 64'd0);
      end
   endtask

   // Monitor: every presented prediction is matched against the oldest expectation
   always @(negedge clock) begin
      exp_t e;
      if (predValid === 1'b1) begin
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_pred: got pred_valid=1 expected no prediction");
         end else begin
            e = expQ.pop_front();
            checkOutput("pred_taken", {63'd0, predTaken}, {63'd0, e.taken});
            checkOutput("pred_target", predTarget, e.target);
         end
      end
   end

   // Directed scenarios, random traffic, mid-run reset, then the summary
   initial begin
      logic [63:0] rpc;
      logic [63:0] rupc;
      logic [63:0] rtgt;
      reset       = 1'b1;
      lookupValid = 1'b0;
      lookupPc    = 64'd0;
      updValid    = 1'b0;
      updPc       = 64'd0;
      updIsJump   = 1'b0;
      updTaken    = 1'b0;
      updTarget   = 64'd0;
      modelReset();

      repeat (3) begin
         @(posedge clock);
         #1;
      end
      checkOutput("reset_ready", {63'd0, readyOut}, 64'd0);
      checkOutput("reset_pred_valid", {63'd0, predValid}, 64'd0);
      checkOutput("reset_pred_taken", {63'd0, predTaken}, 64'd0);
      checkOutput("reset_pred_target", predTarget, 64'd0);
      reset = 1'b0;
      $display("[TB] reset released, checking init sweep");
      checkInitSweep(1'b1);

      lookupOnly(64'h1000);

      $display("[TB] counter training at 0x2000");
      for (int i = 0; i < 3; i++) begin
         updateOnly(64'h2000, 1'b0, 1'b1, 64'h2400);
         lookupOnly(64'h2000);
      end
      for (int i = 0; i < 2; i++) begin
         updateOnly(64'h2000, 1'b0, 1'b0, 64'h0);
         lookupOnly(64'h2000);
      end

      $display("[TB] saturation at 0x3000");
      for (int i = 0; i < 5; i++) updateOnly(64'h3000, 1'b0, 1'b0, 64'h0);
      updateOnly(64'h3000, 1'b0, 1'b1, 64'h3800);
      lookupOnly(64'h3000);

      $display("[TB] jump and aliasing at 0x4000");
      updateOnly(64'h4000, 1'b1, 1'b1, 64'h5000);
      lookupOnly(64'h4000);
      lookupOnly(64'h4000 + (64'd1 << 8));

      $display("[TB] same-cycle bypass at 0x6000");
      applyStimulus(1'b1, 64'h6000, 1'b1, 64'h6000, 1'b0, 1'b1, 64'h6100);
      applyStimulus(1'b1, 64'h6004, 1'b1, 64'h7004, 1'b1, 1'b1, 64'h7100);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         rpc  = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2) |
                64'($urandom_range(0, 3)) | (64'($urandom_range(0, 1)) << 30);
         rupc = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2) |
                64'($urandom_range(0, 3)) | (64'($urandom_range(0, 1)) << 40);
         rtgt = {32'($urandom), 32'($urandom)} & ~64'd1;
         applyStimulus(bit'($urandom_range(0, 1)), rpc, bit'($urandom_range(0, 1)), rupc,
                       ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), rtgt);
      end

      $display("[TB] mid-operation reset");
      updateOnly(64'h2000, 1'b0, 1'b1, 64'h2400);
      updateOnly(64'h2000, 1'b0, 1'b1, 64'h2400);
      lookupOnly(64'h2000);
      pulseReset(1);
      checkOutput("midreset_ready", {63'd0, readyOut}, 64'd0);
      checkOutput("midreset_pred_valid", {63'd0, predValid}, 64'd0);
      checkInitSweep(1'b0);
      lookupOnly(64'h2000);

      repeat (3) idleCycle();
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
